miner_noc_endpoint: RTL and testbench

MINER_NOC_ENDPOINT -- requirements
Module: miner_noc_endpoint

---
 rtl/miner_noc_endpoint_pkg.sv | 41 ++++
 rtl/miner_noc_endpoint_credit.sv | 27 ++
 rtl/miner_noc_endpoint.sv | 139 +++++++++++++
 tb/tb_miner_noc_endpoint.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/miner_noc_endpoint_pkg.sv
// Shared definitions for the miner NoC endpoint: flit field layout, FSM state
// encodings and reply message constants.
package miner_noc_endpoint_pkg;

  // Matches the flit data width used across the NoC (connect_parameters).
  localparam int FLIT_DATA_WIDTH = 64;
  localparam int FLIT_W          = 73;
  localparam int FLIT_VALID_BIT  = 72;
  localparam int FLIT_TAIL_BIT   = 71;
  localparam int FLIT_DEST_LSB   = 66;
  localparam int FLIT_DEST_W     = 5;
  localparam int FLIT_VC_LSB     = 64;
  localparam int FLIT_VC_W       = 2;
  localparam int CREDIT_W        = 3;

  localparam int HDR_FLITS = 10;
  localparam int HDR_W     = HDR_FLITS * FLIT_DATA_WIDTH;
  localparam int IDX_W     = 4;
  localparam int CNT_W     = 5;

  localparam logic [FLIT_DATA_WIDTH-1:0] FOUND_MSG = 64'h1;

  typedef enum logic [2:0] {
    RX_HDR   = 3'd0,
    HASH     = 3'd1,
    TX_FOUND = 3'd2,
    TX_NONCE = 3'd3,
    TX_CLKS  = 3'd4,
    DONE     = 3'd5
  } ep_state_e;

  function automatic logic [FLIT_W-1:0] make_flit(
    input logic                       tail,
    input logic [FLIT_DEST_W-1:0]     dest,
    input logic [FLIT_VC_W-1:0]       vc,
    input logic [FLIT_DATA_WIDTH-1:0] data
  );
    return {1'b1, tail, dest, vc, data};
  endfunction

endpackage

// File: rtl/miner_noc_endpoint_credit.sv
// miner_credit_counter: transmit credit tracker, starts full and saturates at
// CREDIT_INIT; a returned credit and a send in the same cycle cancel out.
module miner_credit_counter
  import miner_noc_endpoint_pkg::*;
#(
  parameter int CREDIT_INIT = 16
) (
  input  logic             sys_clk,
  input  logic             nreset,
  input  logic             credit_in,
  input  logic             send,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CMAX = CNT_W'(CREDIT_INIT);

  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset) begin
      count <= CMAX;
    end else if (credit_in && !send) begin
      if (count < CMAX) count <= count + CNT_W'(1);
    end else if (send && !credit_in) begin
      if (count != '0) count <= count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/miner_noc_endpoint.sv
// Miner NoC endpoint: gathers a 10-flit block header, times the hash core, and
// replies FOUND / nonce / cycle count. Macro MINER_EP_CLKCNT_EN builds the counter.
module miner_noc_endpoint
  import miner_noc_endpoint_pkg::*;
#(
  parameter logic [FLIT_DEST_W-1:0] CTRL_ADDR   = 5'd0,
  parameter logic [FLIT_VC_W-1:0]   REPLY_VC    = 2'd0,
  parameter int                     CREDIT_INIT = 16
) (
  input  logic                sys_clk,
  input  logic                nreset,
  input  logic [FLIT_W-1:0]   getFlit,
  output logic                EN_getFlit,
  output logic [CREDIT_W-1:0] putCredits,
  output logic                EN_putCredits,
  output logic [FLIT_W-1:0]   putFlit,
  output logic                EN_putFlit,
  input  logic [CREDIT_W-1:0] getCredits,
  output logic                EN_getCredits,
  output logic [HDR_W-1:0]    hdr_data,
  output logic                hdr_valid,
  input  logic                found,
  input  logic [31:0]         found_nonce
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(HDR_FLITS - 1);

  ep_state_e                  state, state_nxt;
  logic [IDX_W-1:0]           flit_idx;
  logic [31:0]                nonce;
  logic [FLIT_DATA_WIDTH-1:0] clks_data;
  logic [CNT_W-1:0]           credit_cnt;
  logic                       flit_acc, rx_tail, send, hdr_done;
  logic [FLIT_VC_W-1:0]       rx_vc;
  logic [FLIT_DATA_WIDTH-1:0] rx_data;
  logic                       unused_bits;

  assign flit_acc      = EN_getFlit & getFlit[FLIT_VALID_BIT];
  assign rx_tail       = getFlit[FLIT_TAIL_BIT];
  assign rx_vc         = getFlit[FLIT_VC_LSB +: FLIT_VC_W];
  assign rx_data       = getFlit[FLIT_DATA_WIDTH-1:0];
  assign hdr_done      = (state == RX_HDR) && flit_acc && rx_tail && (flit_idx == LAST_IDX);
  assign EN_getCredits = 1'b1;
  assign unused_bits   = ^{getFlit[FLIT_DEST_LSB +: FLIT_DEST_W], getCredits[FLIT_VC_W-1:0]};

  // Ready only once out of reset; every valid flit is taken and credited back.
  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset) begin
      EN_getFlit    <= 1'b0;
      EN_putCredits <= 1'b0;
      putCredits    <= '0;
    end else begin
      EN_getFlit    <= 1'b1;
      EN_putCredits <= flit_acc;
      putCredits    <= flit_acc ? {1'b1, rx_vc} : '0;
    end
  end

  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset) begin
      flit_idx  <= '0;
      hdr_data  <= '0;
      hdr_valid <= 1'b0;
    end else begin
      hdr_valid <= hdr_done;
      if (state == RX_HDR && flit_acc) begin
        for (int k = 0; k < HDR_FLITS; k++) begin
          if (flit_idx == IDX_W'(k)) hdr_data[k*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH] <= rx_data;
        end
        if (rx_tail || flit_idx == LAST_IDX) flit_idx <= '0;
        else                                 flit_idx <= flit_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset)                     nonce <= '0;
    else if (state == HASH && found) nonce <= found_nonce;
  end

`ifdef MINER_EP_CLKCNT_EN
  logic [63:0] clk_cnt;

  // Starts from zero on the header pulse and stops on the cycle found is seen.
  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset)                      clk_cnt <= '0;
    else if (hdr_valid)               clk_cnt <= '0;
    else if (state == HASH && !found) clk_cnt <= clk_cnt + 64'd1;
  end

  assign clks_data = clk_cnt;
`else
  assign clks_data = '0;
`endif

  miner_credit_counter #(
    .CREDIT_INIT (CREDIT_INIT)
  ) u_credit (
    .sys_clk   (sys_clk),
    .nreset    (nreset),
    .credit_in (getCredits[CREDIT_W-1]),
    .send      (send),
    .count     (credit_cnt)
  );

  always_ff @(posedge sys_clk or negedge nreset) begin
    if (!nreset) state <= RX_HDR;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    send       = 1'b0;
    putFlit    = '0;
    case (state)
      RX_HDR:   if (hdr_done) state_nxt = HASH;
      HASH:     if (found) state_nxt = TX_FOUND;
      TX_FOUND: if (credit_cnt != '0) begin
        send      = 1'b1;
        putFlit   = make_flit(1'b0, CTRL_ADDR, REPLY_VC, FOUND_MSG);
        state_nxt = TX_NONCE;
      end
      TX_NONCE: if (credit_cnt != '0) begin
        send      = 1'b1;
        putFlit   = make_flit(1'b0, CTRL_ADDR, REPLY_VC, {32'h0, nonce});
        state_nxt = TX_CLKS;
      end
      TX_CLKS:  if (credit_cnt != '0) begin
        send      = 1'b1;
        putFlit   = make_flit(1'b1, CTRL_ADDR, REPLY_VC, clks_data);
        state_nxt = DONE;
      end
      DONE:     state_nxt = DONE;
      default:  state_nxt = RX_HDR;
    endcase
    EN_putFlit = send;
  end

endmodule

// File: tb/tb_miner_noc_endpoint.sv
// Self-checking bench for miner_noc_endpoint: directed sequence with random
// header data, VCs, nonces and hash lengths against a behavioural model.
module tb_miner_noc_endpoint;

  localparam logic [4:0] CA = 5'd19;
  localparam logic [1:0] RV = 2'd2;
`ifdef MINER_EP_CLKCNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic         sys_clk = 1'b0;
  logic         nreset = 1'b0;
  logic [72:0]  getFlit = '0;
  logic         EN_getFlit;
  logic [2:0]   putCredits;
  logic         EN_putCredits;
  logic [72:0]  putFlit;
  logic         EN_putFlit;
  logic [2:0]   getCredits = '0;
  logic         EN_getCredits;
  logic [639:0] hdr_data;
  logic         hdr_valid;
  logic         found = 1'b0;
  logic [31:0]  found_nonce = '0;

  miner_noc_endpoint #(
    .CTRL_ADDR   (CA),
    .REPLY_VC    (RV),
    .CREDIT_INIT (1)
  ) dut (
    .sys_clk       (sys_clk),
    .nreset        (nreset),
    .getFlit       (getFlit),
    .EN_getFlit    (EN_getFlit),
    .putCredits    (putCredits),
    .EN_putCredits (EN_putCredits),
    .putFlit       (putFlit),
    .EN_putFlit    (EN_putFlit),
    .getCredits    (getCredits),
    .EN_getCredits (EN_getCredits),
    .hdr_data      (hdr_data),
    .hdr_valid     (hdr_valid),
    .found         (found),
    .found_nonce   (found_nonce)
  );

  always #5 sys_clk = ~sys_clk;

  int          n_tests = 0;
  int          n_fail = 0;
  bit          chk_on = 1'b0;
  int          hv_cnt = 0;
  logic [2:0]  cred_got[$];
  logic [2:0]  cred_exp[$];
  logic [72:0] tx_got[$];
  logic [63:0] hdr_model[10];

  task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [72:0] mk(input logic tail, input logic [63:0] d);
    return {1'b1, tail, CA, RV, d};
  endfunction

  function automatic logic [639:0] hdr_exp();
    logic [639:0] h;
    for (int i = 0; i < 10; i++) h[64*i +: 64] = hdr_model[i];
    return h;
  endfunction

  // Advance one clock and record what the DUT presents in the new cycle.
  task automatic tick();
    @(posedge sys_clk);
    #1;
    if (EN_putCredits) cred_got.push_back(putCredits);
    if (hdr_valid) hv_cnt++;
    if (EN_putFlit) tx_got.push_back(putFlit);
    if (chk_on) begin
      chk("en_getflit_high", EN_getFlit, 1);
      chk("en_getcredits_high", EN_getCredits, 1);
      if (!EN_putFlit) chk("putflit_idle_zero", putFlit, 0);
      if (!EN_putCredits) chk("putcredits_idle_zero", putCredits, 0);
    end
  endtask

  task automatic put_flit(input logic tail, input logic [1:0] vc, input logic [63:0] d);
    getFlit = {1'b1, tail, 5'($urandom), vc, d};
    cred_exp.push_back({1'b1, vc});
    tick();
    getFlit = '0;
  endtask

  task automatic send_hdr(input int n, input bit rnd);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      d = rnd ? {$urandom, $urandom} : 64'(i);
      hdr_model[i] = d;
      put_flit(i == n - 1, 2'($urandom), d);
    end
  endtask

  task automatic reset_chk(input string tag);
    chk({tag, "_en_getflit"}, EN_getFlit, 0);
    chk({tag, "_en_putflit"}, EN_putFlit, 0);
    chk({tag, "_putflit"}, putFlit, 0);
    chk({tag, "_en_putcredits"}, EN_putCredits, 0);
    chk({tag, "_putcredits"}, putCredits, 0);
    chk({tag, "_hdr_valid"}, hdr_valid, 0);
    chk({tag, "_hdr_data"}, hdr_data, 0);
    chk({tag, "_en_getcredits"}, EN_getCredits, 1);
  endtask

  task automatic do_reset(input string tag);
    nreset = 1'b0;
    #1;
    reset_chk(tag);
    #1 nreset = 1'b1;
    tick();
    cred_got.delete();
    cred_exp.delete();
    tx_got.delete();
    hv_cnt = 0;
  endtask

  task automatic chk_credits(input string tag);
    chk({tag, "_count"}, cred_got.size(), cred_exp.size());
    for (int i = 0; i < cred_exp.size() && i < cred_got.size(); i++)
      chk(tag, cred_got[i], cred_exp[i]);
    cred_got.delete();
    cred_exp.delete();
  endtask

  task automatic chk_tx(input string tag, input int i, input logic [72:0] exp);
    chk(tag, (tx_got.size() > i) ? tx_got[i] : 73'h0, exp);
  endtask

  task automatic give_credit();
    getCredits = {1'b1, 2'($urandom)};
    tick();
    getCredits = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_hash, n2;
    logic [31:0] nonce1, nonce2;
    logic [639:0] hsnap;

    do_reset("reset0");
    chk_on = 1'b1;

    // Found outside HASH is ignored; a credit at full count saturates.
    found = 1'b1; found_nonce = $urandom; tick(); found = 1'b0;
    tick(); tick();
    chk("found_in_rx_ignored", tx_got.size(), 0);
    give_credit();

    // Header with data i in flit i.
    send_hdr(10, 1'b0);
    chk("hdr_valid_pulse", hv_cnt, 1);
    chk("hdr_data_seq", hdr_data, hdr_exp());
    chk_credits("hdr_credits");

    // Flits during HASH are credited but do not touch the header.
    n_hash = $urandom_range(5, 60);
    nonce1 = $urandom;
    hsnap = hdr_exp();
    tick();
    put_flit(1'b0, 2'($urandom), {$urandom, $urandom});
    put_flit(1'b1, 2'($urandom), {$urandom, $urandom});
    chk("hash_flits_discarded", hdr_data, hsnap);
    chk_credits("hash_credits");
    chk("hdr_valid_single", hv_cnt, 1);
    repeat (n_hash - 2) tick();
    found = 1'b1; found_nonce = nonce1; tick(); found = 1'b0;
    found_nonce = $urandom;

    // One credit: FOUND goes out, then each following flit waits for a credit.
    chk("tx_found_sent", tx_got.size(), 1);
    tick(); tick(); tick();
    chk("tx_nonce_stall", tx_got.size(), 1);
    chk("tx_nonce_stall_en", EN_putFlit, 0);
    give_credit();
    chk("tx_nonce_after_credit", tx_got.size(), 2);
    tick();
    chk("tx_clks_stall", tx_got.size(), 2);
    give_credit();
    tick();
    chk("tx_total", tx_got.size(), 3);
    chk_tx("tx_flit_found", 0, mk(1'b0, 64'h1));
    chk_tx("tx_flit_nonce", 1, mk(1'b0, {32'h0, nonce1}));
    chk_tx("tx_flit_clks", 2, mk(1'b1, CNT_EN ? 64'(n_hash) : 64'h0));

    // DONE is terminal: found ignored, flits still credited.
    put_flit(1'b0, 2'($urandom), {$urandom, $urandom});
    found = 1'b1; found_nonce = $urandom; tick(); found = 1'b0;
    give_credit();
    tick(); tick();
    chk("done_no_tx", tx_got.size(), 3);
    chk_credits("done_credits");

    // Reset in the middle of a header.
    do_reset("reset1");
    send_hdr(5, 1'b1);
    do_reset("reset_mid_hdr");

    // Early tail, then a full header.
    send_hdr(5, 1'b1);
    tick();
    chk("early_tail_no_valid", hv_cnt, 0);
    send_hdr(10, 1'b1);
    chk("hdr2_valid_pulse", hv_cnt, 1);
    chk("hdr2_data", hdr_data, hdr_exp());
    chk_credits("hdr2_credits");

    // Credit returned in the same cycle as a send keeps the count unchanged.
    n2 = $urandom_range(1, 40);
    nonce2 = $urandom;
    repeat (n2 + 1) tick();
    found = 1'b1; found_nonce = nonce2; tick(); found = 1'b0;
    chk("tx2_found_sent", tx_got.size(), 1);
    give_credit();
    chk("tx2_nonce_no_stall", tx_got.size(), 2);
    tick();
    chk("tx2_clks_stall", tx_got.size(), 2);
    give_credit();
    tick();
    chk("tx2_total", tx_got.size(), 3);
    chk_tx("tx2_flit_found", 0, mk(1'b0, 64'h1));
    chk_tx("tx2_flit_nonce", 1, mk(1'b0, {32'h0, nonce2}));
    chk_tx("tx2_flit_clks", 2, mk(1'b1, CNT_EN ? 64'(n2) : 64'h0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
